// File: rtl/imem_pkg_hdl.sv
// imem_pkg_hdl -- shared definitions for the instruction-memory responder.
//   IMEM_WORD_W     : instruction word width (16 bits)
//   IMEM_WAIT_CNT_W : width of the wait-state counter (covers 0..15)
//   IMEM_TRAP_HALT  : word returned for an out-of-range fetch (TRAP HALT)
//   imem_state_e    : fetch FSM states
package imem_pkg_hdl;

  localparam int IMEM_WORD_W     = 16;
  localparam int IMEM_WAIT_CNT_W = 4;

  localparam logic [IMEM_WORD_W-1:0] IMEM_TRAP_HALT = 16'hF025;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_array.sv
// imem_array -- 2**ADDR_W x 16 single-port-read / single-port-write memory
// with a registered (synchronous) read port.
//   clock   : rising-edge clock
//   reset   : asynchronous active-low; clears only the read-data register
//   wr_en   : write strobe, wr_addr / wr_data : write port
//   rd_en   : read launch, rd_addr : read address
//   rd_data : registered read data, held until the next rd_en
// A read and a write to the same address on one edge return the old word.
module imem_array
  import imem_pkg_hdl::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [IMEM_WORD_W-1:0] wr_data,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [IMEM_WORD_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [IMEM_WORD_W-1:0] mem [DEPTH];
  logic [IMEM_WORD_W-1:0] rd_data_d, rd_data_q;

  // Storage is never reset so contents survive a responder reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// imem_responder -- instruction-fetch responder with programmable wait states
// and a backdoor preload port.
//   clock, reset   : rising-edge clock, asynchronous active-low reset
//   PC, instrmem_rd: fetch address and request strobe (sampled in IDLE only)
//   instr_dout     : fetched word, held until the next completion
//   complete_instr : one-cycle pulse in the response cycle
//   load_en/addr/data : preload write port, usable in any state
//   busy           : high while a fetch is in flight (WAIT or RESP)
//   oor_err        : one-cycle out-of-range flag, aligned with complete_instr
// Build option: define IMEM_OOR_TRAP_EN to return IMEM_TRAP_HALT and pulse
// oor_err for a PC with any bit above ADDR_W-1 set; otherwise the address
// wraps modulo the depth and oor_err stays 0.
// Assumes ADDR_W < 16.
module imem_responder
  import imem_pkg_hdl::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [IMEM_WORD_W-1:0] PC,
  input  logic                   instrmem_rd,
  output logic [IMEM_WORD_W-1:0] instr_dout,
  output logic                   complete_instr,
  input  logic                   load_en,
  input  logic [ADDR_W-1:0]      load_addr,
  input  logic [IMEM_WORD_W-1:0] load_data,
  output logic                   busy,
  output logic                   oor_err
);

  localparam logic [IMEM_WAIT_CNT_W-1:0] WAIT_INIT = IMEM_WAIT_CNT_W'(WAIT_STATES);
  localparam logic [IMEM_WAIT_CNT_W-1:0] CNT_ONE   = IMEM_WAIT_CNT_W'(1);

  imem_state_e                state_q, state_d;
  logic [IMEM_WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic                       oor_q, oor_d;
  logic                       trap_q, trap_d;

  logic                   pc_hi_set;
  logic                   oor_hit;
  logic                   resp_entry;
  logic [ADDR_W-1:0]      rd_addr;
  logic [IMEM_WORD_W-1:0] arr_dout;

  assign pc_hi_set = (({16'h0000, PC} >> ADDR_W) != 32'd0);

`ifdef IMEM_OOR_TRAP_EN
  assign oor_hit = pc_hi_set;
`else
  logic unused_pc_hi;
  assign unused_pc_hi = pc_hi_set;
  assign oor_hit      = 1'b0;
`endif

  // State register and fetch-context flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      oor_q      <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      oor_q      <= oor_d;
      trap_q     <= trap_d;
    end
  end

  // Captured address is only meaningful while busy, so it needs no reset.
  always_ff @(posedge clock) begin
    addr_q <= addr_d;
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    oor_d      = oor_q;
    case (state_q)
      ST_IDLE: begin
        if (instrmem_rd) begin
          addr_d     = PC[ADDR_W-1:0];
          oor_d      = oor_hit;
          wait_cnt_d = WAIT_INIT;
          state_d    = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q - CNT_ONE;
        if (wait_cnt_q == CNT_ONE) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory read launches on the edge that enters RESP. With zero wait
  // states that is the capture edge itself, so the live PC is used.
  always_comb begin
    resp_entry = (state_d == ST_RESP) && (state_q != ST_RESP);
    rd_addr    = (state_q == ST_IDLE) ? PC[ADDR_W-1:0] : addr_q;
    trap_d     = trap_q;
    if (resp_entry) begin
      trap_d = (state_q == ST_IDLE) ? oor_hit : oor_q;
    end
  end

  imem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (load_en),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_en   (resp_entry),
    .rd_addr (rd_addr),
    .rd_data (arr_dout)
  );

  // Output logic. trap_q is held with the read data, so instr_dout keeps
  // showing the trap word until the next completion.
  always_comb begin
    complete_instr = (state_q == ST_RESP);
    busy           = (state_q != ST_IDLE);
    oor_err        = complete_instr & trap_q;
    instr_dout     = trap_q ? IMEM_TRAP_HALT : arr_dout;
  end

endmodule
